// File: rtl/add64_seq.sv
`default_nettype none
// ============================================================================
// Module   : add64_seq (with helper rca16)
// Purpose  : Multi-cycle W-bit adder/subtractor (W = 16*SLICES). A single
//            16-bit ripple-carry adder is time-shared across the operand,
//            one slice per clock, least-significant slice first. The carry
//            between slices is held in a register, so no combinational path
//            runs from one slice to the next.
// Ports    : clk    - clock, all state changes on the rising edge
//            rst    - synchronous active-high reset
//            start  - request, sampled only while idle
//            a, b   - W-bit operands, captured when start is accepted
//            c_in   - carry-in for add (ignored for subtract)
//            sub    - 0: a+b+c_in, 1: a-b (a + ~b + 1)
//            sum    - registered W-bit result
//            c_out  - final carry (for subtract, 1 = no borrow)
//            ovf    - two's-complement signed overflow of the result
//            busy   - high while an operation is in progress
//            done   - one-cycle pulse, sum/c_out/ovf valid
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// rca16: plain 16-bit ripple-carry adder.
//   a, b  - addends;  c_in - carry in;  sum - 16-bit sum;  c_out - carry out
// ----------------------------------------------------------------------------
module rca16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 16; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    c_out = carry[16];
  end

endmodule

// ----------------------------------------------------------------------------
// add64_seq: sequential slice-by-slice adder/subtractor.
// ----------------------------------------------------------------------------
module add64_seq #(
  parameter int SLICES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*SLICES-1:0] a,
  input  logic [16*SLICES-1:0] b,
  input  logic                 c_in,
  input  logic                 sub,
  output logic [16*SLICES-1:0] sum,
  output logic                 c_out,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int W     = 16 * SLICES;
  localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Captured operands split into 16-bit slices for the slice-select mux.
  logic [15:0] a_slice [SLICES];
  logic [15:0] b_slice [SLICES];

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    assign a_slice[k] = a_q[16*k +: 16];
    assign b_slice[k] = b_q[16*k +: 16];
  end

  logic [15:0] rca_a;
  logic [15:0] rca_b;
  logic [15:0] rca_sum;
  logic        rca_c_out;

  // b is stored raw; inversion for subtract is applied per slice here, so
  // rca_b is B' for the slice currently being processed.
  assign rca_a = a_slice[idx_q];
  assign rca_b = sub_q ? ~b_slice[idx_q] : b_slice[idx_q];

  rca16 u_rca (
    .a     (rca_a),
    .b     (rca_b),
    .c_in  (carry_q),
    .sum   (rca_sum),
    .c_out (rca_c_out)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          // Subtract is a + ~b + 1: the +1 enters as the initial carry.
          carry_d = sub ? 1'b1 : c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int k = 0; k < SLICES; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[16*k +: 16] = rca_sum;
          end
        end
        carry_d = rca_c_out;
        if (idx_q == LAST_IDX) begin
          // Top slice: its MSBs are the sign bits of A, B' and the result.
          c_out_d = rca_c_out;
          ovf_d   = (rca_a[15] == rca_b[15]) && (rca_sum[15] != rca_a[15]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_add64_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add64_seq
// Purpose  : Self-checking bench for add64_seq (SLICES=4, W=64). Expected
//            results are queued when an operation is launched and popped
//            when the DUT pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add64_seq;

  localparam int SLICES = 4;
  localparam int W      = 16 * SLICES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  add64_seq #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sub   (sub),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Word-level reference: B' is ~b for subtract, carry-in forced to 1.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input logic tsub);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   full;
    bp    = tsub ? ~tb_ : tb_;
    full  = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
    e.sum = full[W-1:0];
    e.co  = full[W];
    e.ovf = (ta[W-1] == bp[W-1]) && (full[W-1] != ta[W-1]);
    return e;
  endfunction

  // Launch one operation, queue its expectation, wait for done and compare.
  // With disturb set, start is re-pulsed and all operand inputs flipped
  // while the operation is running; none of that may affect the result.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tcin, input logic tsub,
                       input exp_t e, input bit disturb, input string name);
    exp_t got;
    int   k;
    int   w;
    sb.push_back(e);
    a = ta; b = tb_; c_in = tcin; sub = tsub; start = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!busy && w < 5);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s accept: busy=%b required 1", name, busy);
    end
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      if (disturb && k == 1) begin
        start = 1'b1; a = ~ta; b = ~tb_; c_in = ~tcin; sub = ~tsub;
      end
      if (disturb && k == 2) start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    got = sb.pop_front();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, k);
      return;
    end
    tests_run++;
    if (k !== SLICES) begin
      tests_failed++;
      $display("FAIL %s latency: done %0d cycles after accept, required %0d", name, k, SLICES);
    end
    tests_run++;
    if (sum !== got.sum) begin
      tests_failed++;
      $display("FAIL %s sum: got %h required %h", name, sum, got.sum);
    end
    tests_run++;
    if (c_out !== got.co) begin
      tests_failed++;
      $display("FAIL %s c_out: got %b required %b", name, c_out, got.co);
    end
    tests_run++;
    if (ovf !== got.ovf) begin
      tests_failed++;
      $display("FAIL %s ovf: got %b required %b", name, ovf, got.ovf);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== got.sum) begin
      tests_failed++;
      $display("FAIL %s after_done: done=%b busy=%b sum=%h required 0 0 %h",
               name, done, busy, sum, got.sum);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   k;
    rst = 1'b1; start = 1'b1; a = 64'd3; b = 64'd4; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b ovf=%b required all 0",
               busy, done, sum, c_out, ovf);
    end
    // start held through reset must be taken on the first edge with rst=0.
    rst = 1'b0;
    sb.push_back(model(64'd3, 64'd4, 1'b0, 1'b0));
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_start_accept: busy=%b required 1", busy);
    end
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    tests_run++;
    if (done !== 1'b1 || sum !== e.sum) begin
      tests_failed++;
      $display("FAIL reset_first_op: done=%b sum=%h required 1 %h", done, sum, e.sum);
    end
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    exp_t e;
    e = '{sum: 64'h0, co: 1'b1, ovf: 1'b0};
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, e, 1'b0, "all_ones_plus_cin");
    e = '{sum: 64'h0000_0000_0001_0000, co: 1'b0, ovf: 1'b0};
    do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, e, 1'b0, "slice_carry");
    e = '{sum: 64'hFFFF_FFFF_FFFF_FFFF, co: 1'b0, ovf: 1'b0};
    do_op(64'h0, 64'h1, 1'b1, 1'b1, e, 1'b0, "sub_borrow");
    e = '{sum: 64'h0, co: 1'b1, ovf: 1'b0};
    do_op(64'h5, 64'h5, 1'b0, 1'b1, e, 1'b0, "sub_equal");
    e = '{sum: 64'h8000_0000_0000_0000, co: 1'b0, ovf: 1'b1};
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, e, 1'b0, "pos_overflow");
    e = '{sum: 64'h0, co: 1'b1, ovf: 1'b1};
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, e, 1'b0, "neg_overflow");
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb_;
    logic         tc, ts;
    for (int i = 0; i < 8; i++) begin
      ta  = {$urandom, $urandom};
      tb_ = {$urandom, $urandom};
      tc  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      do_op(ta, tb_, tc, ts, model(ta, tb_, tc, ts), 1'b0, $sformatf("random_%0d", i));
    end
  endtask

  task automatic test_busy_ignore();
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
          model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0),
          1'b1, "busy_ignore_add");
    do_op(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1,
          model(64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1),
          1'b1, "busy_ignore_sub");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e = '{sum: 64'd300, co: 1'b0, ovf: 1'b0};
    do_op(64'd100, 64'd200, 1'b0, 1'b0, e, 1'b0, "b2b_first");
    e = '{sum: 64'hFFFF_FFFF_FFFF_FF9C, co: 1'b0, ovf: 1'b0};
    do_op(64'd100, 64'd200, 1'b0, 1'b1, e, 1'b0, "b2b_second");
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   seen;
    a = 64'h0001_0001_0001_0001; b = 64'h0001_0001_0001_0001;
    c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);  // slices 0 and 1 written, slice 2 next
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || sum !== '0 || c_out !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: busy=%b sum=%h c_out=%b done=%b required 0 0 0 0",
               busy, sum, c_out, done);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_no_done: %0d active cycles after reset, required 0", seen);
    end
    e = '{sum: 64'd20, co: 1'b0, ovf: 1'b0};
    do_op(64'd11, 64'd9, 1'b0, 1'b0, e, 1'b0, "after_mid_reset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    test_reset();
    test_spec_vectors();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add64_seq.md
ADD64_SEQ -- requirements
Module: add64_seq

Interface
REQ-001 The block SHALL have parameter SLICES, default 4: number of 16-bit slices; operand width W = 16*SLICES (64 by default).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  W  operand A; captured when start is accepted.
REQ-006 b  input  W  operand B; captured when start is accepted.
REQ-007 c_in  input  1  carry-in for add; captured when start is accepted; ignored when sub=1.
REQ-008 sub  input  1  mode, 0 = A+B+c_in, 1 = A-B (A + ~B + 1); captured when start is accepted.
REQ-009 sum  output  W  result; registered.
REQ-010 c_out  output  1  final carry out; for sub, 1 = no borrow.
REQ-011 ovf  output  1  two's-complement signed overflow of the W-bit result.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse; sum/c_out/ovf valid.

Function
REQ-014 The block SHALL instantiate exactly one rca16 (ports sum, c_out, a, b, c_in) and compute all W bits through it, one 16-bit slice per cycle, LSB slice first.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-016 IDLE -> RUN on start=1. On that edge: capture a, b, sub and c_in; slice index <= 0; carry register <= (sub ? 1 : c_in).
REQ-017 Each RUN edge SHALL process slice k:
- rca16.a = A[16k+15:16k]
- rca16.b = sub ? ~B slice : B slice
- rca16.c_in = carry register
- write the rca16 sum to sum[16k+15:16k]
- carry register <= rca16 c_out
- k <= k+1
REQ-018 RUN -> DONE on the edge that processes slice SLICES-1. On that edge, c_out <= rca16 c_out, and ovf <= (A[W-1] == B'[W-1]) && (new sum[W-1] != A[W-1]), where B' is the inverted-or-not B operand.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-020 Latency SHALL be as follows:
- start sampled at edge N
- slices processed at edges N+1..N+SLICES
- done high in the cycle following edge N+SLICES
- next start accepted at edge N+SLICES+1 at the earliest
REQ-021 start SHALL be ignored in RUN and DONE; the captured operands SHALL NOT change while busy=1, even if a, b, c_in or sub toggle.
REQ-022 sum, c_out and ovf SHALL hold their values after done until the next accepted start. Upper slices of sum MAY show stale data while busy=1; consumers SHALL use sum only when done=1 or busy=0.
REQ-023 The slice index SHALL be ceil(log2(SLICES)) bits wide (minimum 1), SHALL never exceed SLICES-1, and SHALL NOT wrap inside a single operation.
REQ-024 Carry SHALL propagate slice-to-slice only through the carry register; there SHALL be no combinational path from slice k to slice k+1 within a cycle.

Reset
REQ-025 When rst=1 at a rising edge: state <= IDLE; sum <= 0; c_out <= 0; ovf <= 0; done <= 0; busy <= 0; slice index <= 0; carry register <= 0.
REQ-026 rst SHALL take priority over start and over any in-progress operation. A partial result SHALL be discarded, and no done pulse SHALL follow a reset.
REQ-027 start held high during the rst edge SHALL NOT be accepted; it is accepted at the first edge with rst=0.

Verification
REQ-028 a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1, sub=0 -> sum=0, c_out=1, ovf=0; done exactly 4 edges after the start edge.
REQ-029 a=64'h0000_0000_0000_FFFF, b=1, c_in=0, sub=0 -> sum=64'h0000_0000_0001_0000, c_out=0, proving inter-slice carry.
REQ-030 a=0, b=1, sub=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=0, ovf=0. a=5, b=5, sub=1 -> sum=0, c_out=1.
REQ-031 a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, ovf=1, c_out=0. a=b=64'h8000_0000_0000_0000 -> sum=0, ovf=1, c_out=1.
REQ-032 Pulse start again and change a/b while busy=1 -> ignored; result matches the originally captured operands; exactly one done pulse.
REQ-033 Assert rst for one cycle in the middle of RUN (slice 2) -> next cycle busy=0, sum=0, c_out=0; no done pulse; a subsequent start (11+9, c_in=0) -> sum=20.
